wb_bus_arbiter: RTL and testbench

Two-master, one-slave Wishbone B4 pipelined arbiter. Lets the instruction and data Wishbone masters of a `wb_ibex_core` share a single memory or peripheral port. It grants the bus for a whole Wishbone cycle (`cyc` high) and tracks outstanding pipelined requests. It holds a grant until every accepted request of that cycle has been acknowledged.

---
 rtl/wb_arb_pkg.sv | 12 +
 rtl/wb_arb_pick.sv | 32 +++
 rtl/wb_bus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone B4 pipelined arbiter.
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int unsigned NumMasters  = 2;
    localparam int unsigned MstIdxWidth = 1;

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational winner select for the arbiter; WB_ARB_ROUND_ROBIN_EN selects
// round-robin tie breaking, otherwise master 0 has fixed priority.
module wb_arb_pick
    import wb_arb_pkg::*;
(
    input  logic [NumMasters-1:0]  cyc,
    input  logic [MstIdxWidth-1:0] last,
    output logic [MstIdxWidth-1:0] win
);

`ifdef WB_ARB_ROUND_ROBIN_EN
    always_comb begin
        win = '1;
        if (cyc[0] && cyc[1]) begin
            win = ~last;
        end else if (cyc[0]) begin
            win = '0;
        end
    end
`else
    logic [MstIdxWidth-1:0] unused_last;
    assign unused_last = last;

    always_comb begin
        win = '1;
        if (cyc[0]) begin
            win = '0;
        end
    end
`endif

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master, one-slave Wishbone B4 pipelined arbiter holding the grant until drained.
// Optional macro WB_ARB_ROUND_ROBIN_EN enables round-robin tie breaking.
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned AdrWidth       = 32,
    parameter int unsigned DatWidth       = 32,
    localparam int unsigned SelWidth      = DatWidth / 8,
    localparam int unsigned OutsWidth     = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                m0_cyc,
    input  logic                m0_stb,
    input  logic                m0_we,
    input  logic [SelWidth-1:0] m0_sel,
    input  logic [AdrWidth-1:0] m0_adr,
    input  logic [DatWidth-1:0] m0_dat_m,
    output logic [DatWidth-1:0] m0_dat_s,
    output logic                m0_ack,
    output logic                m0_err,
    output logic                m0_stall,

    input  logic                m1_cyc,
    input  logic                m1_stb,
    input  logic                m1_we,
    input  logic [SelWidth-1:0] m1_sel,
    input  logic [AdrWidth-1:0] m1_adr,
    input  logic [DatWidth-1:0] m1_dat_m,
    output logic [DatWidth-1:0] m1_dat_s,
    output logic                m1_ack,
    output logic                m1_err,
    output logic                m1_stall,

    output logic                s_cyc,
    output logic                s_stb,
    output logic                s_we,
    output logic [SelWidth-1:0] s_sel,
    output logic [AdrWidth-1:0] s_adr,
    output logic [DatWidth-1:0] s_dat_m,
    input  logic [DatWidth-1:0] s_dat_s,
    input  logic                s_ack,
    input  logic                s_err,
    input  logic                s_stall
);

    logic [NumMasters-1:0] m_cyc;
    logic [NumMasters-1:0] m_stb;
    logic [NumMasters-1:0] m_we;
    logic [SelWidth-1:0]   m_sel   [NumMasters];
    logic [AdrWidth-1:0]   m_adr   [NumMasters];
    logic [DatWidth-1:0]   m_dat_m [NumMasters];
    logic [NumMasters-1:0] m_ack_out;
    logic [NumMasters-1:0] m_err_out;
    logic [NumMasters-1:0] m_stall_out;
    logic [NumMasters-1:0] m_sel_gnt;

    assign m_cyc      = {m1_cyc, m0_cyc};
    assign m_stb      = {m1_stb, m0_stb};
    assign m_we       = {m1_we, m0_we};
    assign m_sel[0]   = m0_sel;
    assign m_sel[1]   = m1_sel;
    assign m_adr[0]   = m0_adr;
    assign m_adr[1]   = m1_adr;
    assign m_dat_m[0] = m0_dat_m;
    assign m_dat_m[1] = m1_dat_m;

    arb_state_t             state_reg, state_next;
    logic [MstIdxWidth-1:0] gnt_reg, gnt_next;
    logic [OutsWidth-1:0]   outs_reg, outs_next;
    logic [MstIdxWidth-1:0] last_val;
    logic [MstIdxWidth-1:0] pick_win;

    logic busy;
    logic gnt_cyc;
    logic full;
    logic accept;
    logic retire;

    assign busy    = (state_reg == BUSY);
    assign gnt_cyc = m_cyc[gnt_reg];
    assign full    = (outs_reg == OutsWidth'(MaxOutstanding));

    // Dropping cyc while requests are in flight aborts the cycle immediately.
    assign s_cyc   = busy & gnt_cyc;
    assign s_stb   = s_cyc & m_stb[gnt_reg] & ~full;
    assign s_we    = m_we[gnt_reg];
    assign s_sel   = m_sel[gnt_reg];
    assign s_adr   = m_adr[gnt_reg];
    assign s_dat_m = m_dat_m[gnt_reg];

    assign accept  = s_stb & ~s_stall;
    // Responses with nothing outstanding are dropped so the counter never wraps.
    assign retire  = s_cyc & (s_ack | s_err) & (outs_reg != '0);

    for (genvar gi = 0; gi < NumMasters; gi++) begin : g_master
        assign m_sel_gnt[gi]   = busy & (gnt_reg == MstIdxWidth'(gi));
        assign m_stall_out[gi] = ~m_sel_gnt[gi] | s_stall | full;
        assign m_ack_out[gi]   = m_sel_gnt[gi] & gnt_cyc & s_ack;
        assign m_err_out[gi]   = m_sel_gnt[gi] & gnt_cyc & s_err;
    end

    assign m0_stall = m_stall_out[0];
    assign m0_ack   = m_ack_out[0];
    assign m0_err   = m_err_out[0];
    assign m0_dat_s = s_dat_s;
    assign m1_stall = m_stall_out[1];
    assign m1_ack   = m_ack_out[1];
    assign m1_err   = m_err_out[1];
    assign m1_dat_s = s_dat_s;

    wb_arb_pick u_pick (
        .cyc  (m_cyc),
        .last (last_val),
        .win  (pick_win)
    );

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        outs_next  = outs_reg;
        case (state_reg)
            IDLE: begin
                outs_next = '0;
                if (|m_cyc) begin
                    state_next = BUSY;
                    gnt_next   = pick_win;
                end
            end
            BUSY: begin
                if (!gnt_cyc) begin
                    state_next = IDLE;
                    outs_next  = '0;
                end else if (accept && !retire) begin
                    outs_next = outs_reg + OutsWidth'(1);
                end else if (retire && !accept) begin
                    outs_next = outs_reg - OutsWidth'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            outs_reg  <= '0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            outs_reg  <= outs_next;
        end
    end

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic [MstIdxWidth-1:0] last_reg, last_next;

    always_comb begin
        last_next = last_reg;
        if ((state_reg == IDLE) && (|m_cyc)) begin
            last_next = pick_win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= '1;
        end else begin
            last_reg <= last_next;
        end
    end

    assign last_val = last_reg;
`else
    assign last_val = '1;
`endif

`ifndef SYNTHESIS
    ack_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(s_cyc && (s_ack || s_err) && (outs_reg == '0)));
`endif

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter (MaxOutstanding = 2); expectations follow
// WB_ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_wb_bus_arbiter;

`ifdef WB_ARB_ROUND_ROBIN_EN
    localparam bit RrBuild = 1'b1;
`else
    localparam bit RrBuild = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we, m0_ack, m0_err, m0_stall;
    logic [3:0]  m0_sel;
    logic [31:0] m0_adr, m0_dat_m, m0_dat_s;
    logic        m1_cyc, m1_stb, m1_we, m1_ack, m1_err, m1_stall;
    logic [3:0]  m1_sel;
    logic [31:0] m1_adr, m1_dat_m, m1_dat_s;
    logic        s_cyc, s_stb, s_we, s_ack, s_err, s_stall;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_dat_m, s_dat_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_bus_arbiter #(.MaxOutstanding(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_cyc   (m0_cyc),
        .m0_stb   (m0_stb),
        .m0_we    (m0_we),
        .m0_sel   (m0_sel),
        .m0_adr   (m0_adr),
        .m0_dat_m (m0_dat_m),
        .m0_dat_s (m0_dat_s),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m0_stall (m0_stall),
        .m1_cyc   (m1_cyc),
        .m1_stb   (m1_stb),
        .m1_we    (m1_we),
        .m1_sel   (m1_sel),
        .m1_adr   (m1_adr),
        .m1_dat_m (m1_dat_m),
        .m1_dat_s (m1_dat_s),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .m1_stall (m1_stall),
        .s_cyc    (s_cyc),
        .s_stb    (s_stb),
        .s_we     (s_we),
        .s_sel    (s_sel),
        .s_adr    (s_adr),
        .s_dat_m  (s_dat_m),
        .s_dat_s  (s_dat_s),
        .s_ack    (s_ack),
        .s_err    (s_err),
        .s_stall  (s_stall)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'hF; m0_adr = '0; m0_dat_m = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'hF; m1_adr = '0; m1_dat_m = '0;
        s_ack = 0; s_err = 0; s_stall = 0; s_dat_s = '0;
        #12;
        check_eq("rst_s_cyc",    32'(s_cyc),    32'd0);
        check_eq("rst_s_stb",    32'(s_stb),    32'd0);
        check_eq("rst_m0_stall", 32'(m0_stall), 32'd1);
        check_eq("rst_m1_stall", 32'(m1_stall), 32'd1);
        check_eq("rst_m0_ack",   32'(m0_ack),   32'd0);
        check_eq("rst_m1_err",   32'(m1_err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single master m1: three pipelined reads, slave acks one cycle later.
        step();
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h100; #1;
        check_eq("t1_idle_s_cyc",  32'(s_cyc),    32'd0);
        check_eq("t1_idle_stall",  32'(m1_stall), 32'd1);
        step(); #1;
        check_eq("t1_grant_s_cyc", 32'(s_cyc),    32'd1);
        check_eq("t1_grant_s_stb", 32'(s_stb),    32'd1);
        check_eq("t1_s_adr",       s_adr,         32'h100);
        check_eq("t1_m1_stall",    32'(m1_stall), 32'd0);
        check_eq("t1_m0_stall",    32'(m0_stall), 32'd1);
        step();
        m1_adr = 32'h104; s_ack = 1; s_dat_s = 32'hA0; #1;
        check_eq("t1_ack0",        32'(m1_ack),   32'd1);
        check_eq("t1_dat0",        m1_dat_s,      32'hA0);
        check_eq("t1_m0_noack",    32'(m0_ack),   32'd0);
        check_eq("t1_stb1",        32'(s_stb),    32'd1);
        step();
        m1_adr = 32'h108; s_dat_s = 32'hA1; #1;
        check_eq("t1_ack1",        32'(m1_ack),   32'd1);
        check_eq("t1_m0_stall2",   32'(m0_stall), 32'd1);
        step();
        m1_stb = 0; s_dat_s = 32'hA2; #1;
        check_eq("t1_ack2",        32'(m1_ack),   32'd1);
        check_eq("t1_no_stb",      32'(s_stb),    32'd0);
        step();
        s_ack = 0; m1_cyc = 0; #1;
        check_eq("t1_release",     32'(s_cyc),    32'd0);
        step();

        // Simultaneous request straight after reset, then re-request.
        rst_n = 0; #1; rst_n = 1;
        m0_cyc = 1; m1_cyc = 1;
        step(); #1;
        check_eq("t2_tie_m0_gnt",  32'(m0_stall), 32'd0);
        check_eq("t2_tie_m1_wait", 32'(m1_stall), 32'd1);
        m0_cyc = 0; #1;
        check_eq("t2_drop_s_cyc",  32'(s_cyc),    32'd0);
        step();
        m0_cyc = 1; #1;
        check_eq("t2_idle_m0",     32'(m0_stall), 32'd1);
        check_eq("t2_idle_m1",     32'(m1_stall), 32'd1);
        step(); #1;
        check_eq("t2_regrant_m1",  32'(m1_stall), RrBuild ? 32'd0 : 32'd1);
        check_eq("t2_regrant_m0",  32'(m0_stall), RrBuild ? 32'd1 : 32'd0);
        m0_cyc = 0; m1_cyc = 0;
        step();

        // Outstanding limit of 2 with slave withholding ack; hold until drained.
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h200;
        step(); #1;
        check_eq("t3_stb_o0",      32'(s_stb),    32'd1);
        step(); #1;
        check_eq("t3_stb_o1",      32'(s_stb),    32'd1);
        step();
        m1_cyc = 1; #1;
        check_eq("t3_full_stall",  32'(m0_stall), 32'd1);
        check_eq("t3_full_no_stb", 32'(s_stb),    32'd0);
        check_eq("t3_m1_wait",     32'(m1_stall), 32'd1);
        step();
        s_ack = 1; #1;
        check_eq("t3_ack_full",    32'(m0_ack),   32'd1);
        check_eq("t3_ack_no_stb",  32'(s_stb),    32'd0);
        step(); #1;
        check_eq("t3_reaccept",    32'(s_stb),    32'd1);
        step();
        s_ack = 0; #1;
        check_eq("t3_same_outs",   32'(s_stb),    32'd1);
        step();
        m0_stb = 0; #1;
        check_eq("t3_full_again",  32'(m0_stall), 32'd1);
        step();
        s_ack = 1; #1;
        check_eq("t3_drain_ack0",  32'(m0_ack),   32'd1);
        step(); #1;
        check_eq("t3_hold_m1",     32'(m1_stall), 32'd1);
        step();
        s_ack = 0; m0_cyc = 0; #1;
        check_eq("t3_rel_s_cyc",   32'(s_cyc),    32'd0);
        check_eq("t3_rel_m1_wait", 32'(m1_stall), 32'd1);
        step(); #1;
        check_eq("t3_idle_m1",     32'(m1_stall), 32'd1);
        step(); #1;
        check_eq("t3_m1_granted",  32'(m1_stall), 32'd0);
        check_eq("t3_m1_s_cyc",    32'(s_cyc),    32'd1);

        // Error on the second of two writes from m1.
        m1_stb = 1; m1_we = 1; m1_adr = 32'h300; m1_dat_m = 32'hDEAD_BEEF; #1;
        check_eq("t4_s_we",        32'(s_we),     32'd1);
        check_eq("t4_s_dat_m",     s_dat_m,       32'hDEAD_BEEF);
        step();
        s_ack = 1; #1;
        check_eq("t4_ack1",        32'(m1_ack),   32'd1);
        step();
        s_ack = 0; s_err = 1; m1_stb = 0; #1;
        check_eq("t4_m1_err",      32'(m1_err),   32'd1);
        check_eq("t4_m0_no_err",   32'(m0_err),   32'd0);
        check_eq("t4_m1_no_ack",   32'(m1_ack),   32'd0);
        step();
        s_err = 0; m1_cyc = 0; m1_we = 0; #1;
        check_eq("t4_release",     32'(s_cyc),    32'd0);
        step();
        m0_cyc = 1; #1;
        check_eq("t4_idle_m0",     32'(m0_stall), 32'd1);
        step(); #1;
        check_eq("t4_m0_granted",  32'(m0_stall), 32'd0);

        // Async reset while BUSY with two requests outstanding.
        m0_stb = 1;
        step();
        step(); #1;
        check_eq("t5_full",        32'(m0_stall), 32'd1);
        check_eq("t5_busy",        32'(s_cyc),    32'd1);
        rst_n = 0; #1;
        check_eq("t5_rst_s_cyc",   32'(s_cyc),    32'd0);
        check_eq("t5_rst_s_stb",   32'(s_stb),    32'd0);
        check_eq("t5_rst_m0_stall",32'(m0_stall), 32'd1);
        check_eq("t5_rst_m1_stall",32'(m1_stall), 32'd1);
        m0_cyc = 0; m0_stb = 0;
        step();
        rst_n = 1; s_ack = 1; #1;
        check_eq("t5_stray_m0",    32'(m0_ack),   32'd0);
        check_eq("t5_stray_m1",    32'(m1_ack),   32'd0);
        step();
        s_ack = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
